phase_step_quantizer: RTL and testbench
=======================================

PHASE_STEP_QUANTIZER -- requirements
Module: phase_step_quantizer

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default `FIXDT_64_A_WIDTH, signed fixed-point phase width.
REQ-002 SHALL have parameter M_2_PI, default `M_2_PI_64B_A, 2*pi in the input format.
REQ-003 SHALL have parameter SAMPLES_PER_PERIOD, default `CARRIER_SAMPLES_PER_PERIOD, number of quantization steps; power of two >= 2.
REQ-004 SHALL have parameter MAX_WRAP_ITERS, default 4, upper bound on modulo-2pi add/subtract iterations.
REQ-005 SHALL have port clk, input, 1, single clock for the block.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1), input handshake.
REQ-008 SHALL have port in_phase, input, INPUT_WIDTH, signed phase value.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), output handshake.
REQ-010 SHALL have port out_step, output, STEP_BITS = $clog2(SAMPLES_PER_PERIOD), quantized phase index.
REQ-011 SHALL have port out_wrap_err, output, 1, set with out_step when wrapping did not converge.

Function
REQ-012 SHALL derive PHASE_STEP = M_2_PI / SAMPLES_PER_PERIOD at elaboration time.
REQ-013 SHALL implement FSM IDLE -> WRAP -> QUANT -> DONE -> IDLE.
REQ-014 SHALL assert in_ready only in IDLE; in_phase is captured when in_valid && in_ready.
REQ-015 WRAP, one iteration per cycle: if value < 0, add M_2_PI; else if value >= M_2_PI, subtract M_2_PI; else go to QUANT.
REQ-016 If WRAP reaches MAX_WRAP_ITERS without convergence, SHALL go to QUANT with value forced to 0 and wrap_err set.
REQ-017 QUANT SHALL compute floor(value / PHASE_STEP) by restoring division, one quotient bit per cycle, MSB first, exactly STEP_BITS cycles.
REQ-018 Intermediate arithmetic SHALL be INPUT_WIDTH+1 bits signed, so adding M_2_PI cannot overflow.
REQ-019 DONE SHALL hold out_valid=1 with stable out_step and out_wrap_err until out_ready=1, then go to IDLE.
REQ-020 An in_phase equal to M_2_PI exactly SHALL yield step 0; a value of exactly 0 SHALL yield step 0.
REQ-021 Latency from accept to out_valid SHALL be 1 + n_wrap + STEP_BITS cycles, where n_wrap is the number of iterations performed (final check cycle included).
REQ-022 SHALL never accept a new input while a result is pending, so there is no overlap and no drops.

Reset
REQ-023 While rst_n=0, SHALL set state=IDLE, in_ready=0, out_valid=0, out_step=0, out_wrap_err=0, internal registers 0.
REQ-024 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-025 Reset asserted mid-WRAP, mid-QUANT or in DONE SHALL abort the operation with no output produced.

Configuration
REQ-026 Macro PHASE_QUANT_ROUND_EN defined: SHALL add PHASE_STEP/2 before QUANT, giving round-to-nearest; a result equal to SAMPLES_PER_PERIOD SHALL wrap to 0.
REQ-027 Macro PHASE_QUANT_ROUND_EN undefined: SHALL truncate (floor), with no extra adder present.

Structure
REQ-028 STEP_BITS width typedef, PHASE_STEP constant and FSM state enum SHALL live in shared package modem_pkg, alongside the params.svh macros.
REQ-029 Division SHALL be one sub-module, phase_step_divider (start/done, iterative restoring), instantiated once.

Verification (SAMPLES_PER_PERIOD=16, 64-bit A format)
REQ-030 in_phase=64'sh00003243f6a8885a (2pi) -> out_step=0, wrap_err=0, after one wrap iteration.
REQ-031 in_phase=0 -> out_step=0, latency 1+1+4 cycles.
REQ-032 in_phase=64'sh00002de31f8a0903 (5.7359) -> out_step=14 when truncating; 15 with PHASE_QUANT_ROUND_EN.
REQ-033 in_phase=64'shffffea1ce075f6fd (-2.7359) -> out_step=9 (wrapped to 3.5473).
REQ-034 in_phase=20*pi with MAX_WRAP_ITERS=4 -> out_step=0, out_wrap_err=1.
REQ-035 Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_step and out_wrap_err stay stable and in_ready=0; then assert rst_n=0 mid-QUANT -> all outputs 0 at once.

Source files
------------

// File: rtl/modem_pkg.sv
// Shared modem definitions: fixed-point format macros, step width, phase step and FSM states.
// Macros below provide defaults only; a build may predefine them.
`ifndef FIXDT_64_A_WIDTH
`define FIXDT_64_A_WIDTH 64
`endif
`ifndef M_2_PI_64B_A
`define M_2_PI_64B_A 64'sh00003243f6a8885a
`endif
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 16
`endif

package modem_pkg;

  localparam int PHASE_WIDTH        = `FIXDT_64_A_WIDTH;
  localparam int SAMPLES_PER_PERIOD = `CARRIER_SAMPLES_PER_PERIOD;
  localparam int STEP_BITS          = $clog2(SAMPLES_PER_PERIOD);

  localparam logic signed [PHASE_WIDTH-1:0] M_2_PI_A   = `M_2_PI_64B_A;
  localparam logic signed [PHASE_WIDTH-1:0] PHASE_STEP = M_2_PI_A / PHASE_WIDTH'(SAMPLES_PER_PERIOD);

  typedef logic [STEP_BITS-1:0] step_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRAP  = 2'd1,
    ST_QUANT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/phase_step_divider.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, QBITS cycles after i_start.
// Dividend and divisor are non-negative; a quotient too large for QBITS saturates to all ones.
module phase_step_divider #(
  parameter int WIDTH = 65,
  parameter int QBITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [QBITS-1:0] o_quotient
);

  localparam int CNT_W = (QBITS > 1) ? $clog2(QBITS) : 1;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [QBITS-1:0] r_quot;
  logic [CNT_W-1:0] r_bit;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_shifted;
  logic             w_fits;

  // Comparing against divisor << bit is the restoring step without shifting the remainder.
  assign w_shifted = r_divisor << r_bit;
  assign w_fits    = (r_rem >= w_shifted);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_divisor <= '0;
      r_quot    <= '0;
      r_bit     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem     <= i_dividend;
        r_divisor <= i_divisor;
        r_quot    <= '0;
        r_bit     <= CNT_W'(QBITS - 1);
        r_busy    <= 1'b1;
      end else if (r_busy) begin
        if (w_fits) begin
          r_rem         <= r_rem - w_shifted;
          r_quot[r_bit] <= 1'b1;
        end
        if (r_bit == '0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_bit <= r_bit - CNT_W'(1);
        end
      end
    end
  end

  assign o_done     = r_done;
  assign o_quotient = r_quot;

endmodule

// File: rtl/phase_step_quantizer.sv
// Wraps a signed phase into [0, 2pi) and quantizes it to a step index of SAMPLES_PER_PERIOD steps.
// Build option PHASE_QUANT_ROUND_EN selects round-to-nearest; otherwise the index is floored.
//
// state | meaning
// IDLE  | waiting for a phase, in_ready high
// WRAP  | one +/-2pi correction or final range check per cycle
// QUANT | divider producing one quotient bit per cycle
// DONE  | result held on out_step until out_ready
module phase_step_quantizer
  import modem_pkg::*;
#(
  parameter int                            INPUT_WIDTH        = `FIXDT_64_A_WIDTH,
  parameter logic signed [INPUT_WIDTH-1:0] M_2_PI             = `M_2_PI_64B_A,
  parameter int                            SAMPLES_PER_PERIOD = `CARRIER_SAMPLES_PER_PERIOD,
  parameter int                            MAX_WRAP_ITERS     = 4,
  localparam int                           STEP_W             = $clog2(SAMPLES_PER_PERIOD)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [INPUT_WIDTH-1:0] in_phase,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [STEP_W-1:0]             out_step,
  output logic                          out_wrap_err
);

  localparam int EXT_W  = INPUT_WIDTH + 1;
  localparam int ITER_W = $clog2(MAX_WRAP_ITERS + 1);

  localparam logic signed [EXT_W-1:0] M2PI_X = {M_2_PI[INPUT_WIDTH-1], M_2_PI};
  localparam logic signed [EXT_W-1:0] STEP_X = M2PI_X / EXT_W'(SAMPLES_PER_PERIOD);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [EXT_W-1:0]   r_value;
  logic [ITER_W-1:0]         r_iter;
  logic                      r_wrap_err;
  logic [STEP_W-1:0]         r_step;
  logic                      r_ready;

  logic                      w_accept;
  logic                      w_neg;
  logic                      w_over;
  logic                      w_in_range;
  logic                      w_iter_last;
  logic                      w_div_start;
  logic                      w_div_done;
  logic [STEP_W-1:0]         w_quotient;
  logic signed [EXT_W-1:0]   w_quant_in;
  logic [EXT_W-1:0]          w_dividend;

  assign w_accept    = (r_state == ST_IDLE) && in_valid && r_ready;
  assign w_neg       = r_value[EXT_W-1];
  assign w_over      = (r_value >= M2PI_X);
  assign w_in_range  = !w_neg && !w_over;
  assign w_iter_last = (r_iter == ITER_W'(MAX_WRAP_ITERS - 1));
  // A phase that never converged is quantized as zero.
  assign w_quant_in  = w_in_range ? r_value : '0;

`ifdef PHASE_QUANT_ROUND_EN
  localparam logic signed [EXT_W-1:0] HALF_X = STEP_X >>> 1;
  localparam logic signed [EXT_W-1:0] FULL_X = STEP_X <<< STEP_W;

  logic signed [EXT_W-1:0] w_rounded;

  // Rounding past the last step folds back to step 0.
  assign w_rounded  = w_quant_in + HALF_X;
  assign w_dividend = (w_rounded >= FULL_X) ? w_rounded - FULL_X : w_rounded;
`else
  assign w_dividend = w_quant_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_start = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_WRAP;
      ST_WRAP: begin
        if (w_in_range || w_iter_last) begin
          w_state_nxt = ST_QUANT;
          w_div_start = 1'b1;
        end
      end
      ST_QUANT: if (w_div_done) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value    <= '0;
      r_iter     <= '0;
      r_wrap_err <= 1'b0;
      r_step     <= '0;
      r_ready    <= 1'b0;
    end else begin
      // Registered so in_ready stays low throughout reset and rises one edge after release.
      r_ready <= (w_state_nxt == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_value    <= {in_phase[INPUT_WIDTH-1], in_phase};
            r_iter     <= '0;
            r_wrap_err <= 1'b0;
          end
        end
        ST_WRAP: begin
          if (!w_in_range) begin
            if (w_iter_last) begin
              r_value    <= '0;
              r_wrap_err <= 1'b1;
            end else begin
              r_value <= w_neg ? r_value + M2PI_X : r_value - M2PI_X;
              r_iter  <= r_iter + ITER_W'(1);
            end
          end
        end
        ST_QUANT: if (w_div_done) r_step <= w_quotient;
        default: ;
      endcase
    end
  end

  phase_step_divider #(
    .WIDTH (EXT_W),
    .QBITS (STEP_W)
  ) u_divider (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (w_dividend),
    .i_divisor  (STEP_X),
    .o_done     (w_div_done),
    .o_quotient (w_quotient)
  );

  assign in_ready     = r_ready;
  assign out_valid    = (r_state == ST_DONE);
  assign out_step     = r_step;
  assign out_wrap_err = r_wrap_err;

endmodule

// File: tb/tb_phase_step_quantizer.sv
// Directed bench for phase_step_quantizer (16 steps, 64-bit phase, 43 fraction bits).
// Expected steps follow the PHASE_QUANT_ROUND_EN setting of the build.
module tb_phase_step_quantizer;

  localparam logic signed [63:0] TWO_PI   = 64'sh00003243f6a8885a;
  localparam logic signed [63:0] PS       = TWO_PI >>> 4;
  localparam logic signed [63:0] PH_5_73  = 64'sh00002de31f8a0903;
  localparam logic signed [63:0] PH_M2_73 = 64'shffffea1ce075f6fd;
  localparam logic signed [63:0] PH_20PI  = 64'sh0001f6a7a2955384;

`ifdef PHASE_QUANT_ROUND_EN
  localparam logic [3:0] EXP_5_73      = 4'd15;
  localparam logic [3:0] EXP_M2_73     = 4'd9;
  localparam logic [3:0] EXP_3PS_M1    = 4'd3;
  localparam logic [3:0] EXP_NEG_HALF  = 4'd0;
`else
  localparam logic [3:0] EXP_5_73      = 4'd14;
  localparam logic [3:0] EXP_M2_73     = 4'd9;
  localparam logic [3:0] EXP_3PS_M1    = 4'd2;
  localparam logic [3:0] EXP_NEG_HALF  = 4'd15;
`endif

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [63:0] in_phase;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_step;
  logic               out_wrap_err;

  int                 n_checks = 0;
  int                 n_pass   = 0;

  modem_pkg::step_t   st;
  logic               err;
  int                 lat;
  bit                 to;

  phase_step_quantizer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_phase     (in_phase),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_step     (out_step),
    .out_wrap_err (out_wrap_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offers one phase, measures edges from accept to out_valid, then pops the result.
  task automatic do_op(input logic signed [63:0] ph, output int l, output modem_pkg::step_t s,
                       output logic e, output bit t);
    int n;
    t = 1'b0;
    s = '0;
    e = 1'b0;
    l = 0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      t = 1'b1;
      return;
    end
    in_valid = 1'b1;
    in_phase = ph;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && l < 50) begin
      @(posedge clk); #1;
      l++;
    end
    if (!out_valid) begin
      t = 1'b1;
      return;
    end
    s = out_step;
    e = out_wrap_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_phase  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_step !== 4'd0) $display("FAIL reset_out_step: got %0d expected 0", out_step);
    else n_pass++;
    n_checks++;
    if (out_wrap_err !== 1'b0) $display("FAIL reset_wrap_err: got %b expected 0", out_wrap_err);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL ready_before_edge: got %b expected 0", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL ready_first_edge: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_zero();
    do_op(64'sd0, lat, st, err, to);
    n_checks++;
    if (to || st !== 4'd0) $display("FAIL zero_step: got %0d expected 0 (timeout %0d)", st, to);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL zero_wrap_err: got %b expected 0", err);
    else n_pass++;
    n_checks++;
    if (lat !== 6) $display("FAIL zero_latency: got %0d expected 6", lat);
    else n_pass++;
  endtask

  task automatic test_two_pi();
    do_op(TWO_PI, lat, st, err, to);
    n_checks++;
    if (to || st !== 4'd0) $display("FAIL two_pi_step: got %0d expected 0 (timeout %0d)", st, to);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL two_pi_wrap_err: got %b expected 0", err);
    else n_pass++;
  endtask

  task automatic test_quantize();
    do_op(PH_5_73, lat, st, err, to);
    n_checks++;
    if (to || st !== EXP_5_73) $display("FAIL step_5_73: got %0d expected %0d", st, EXP_5_73);
    else n_pass++;
    n_checks++;
    if (lat !== 6) $display("FAIL latency_5_73: got %0d expected 6", lat);
    else n_pass++;
    do_op(PH_M2_73, lat, st, err, to);
    n_checks++;
    if (to || st !== EXP_M2_73) $display("FAIL step_neg_2_73: got %0d expected %0d", st, EXP_M2_73);
    else n_pass++;
    n_checks++;
    if (lat !== 7) $display("FAIL latency_neg_2_73: got %0d expected 7", lat);
    else n_pass++;
    do_op(PS * 3, lat, st, err, to);
    n_checks++;
    if (to || st !== 4'd3) $display("FAIL step_exact_3: got %0d expected 3", st);
    else n_pass++;
    do_op(PS * 3 - 1, lat, st, err, to);
    n_checks++;
    if (to || st !== EXP_3PS_M1) $display("FAIL step_below_3: got %0d expected %0d", st, EXP_3PS_M1);
    else n_pass++;
  endtask

  task automatic test_wrap_err();
    do_op(PH_20PI, lat, st, err, to);
    n_checks++;
    if (to || st !== 4'd0) $display("FAIL wrap_err_step: got %0d expected 0", st);
    else n_pass++;
    n_checks++;
    if (err !== 1'b1) $display("FAIL wrap_err_flag: got %b expected 1", err);
    else n_pass++;
    n_checks++;
    if (lat !== 9) $display("FAIL wrap_err_latency: got %0d expected 9", lat);
    else n_pass++;
  endtask

  task automatic test_hold_and_abort();
    int  n;
    bit  seen;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    in_phase = PH_5_73;
    @(posedge clk); #1;
    in_phase = PH_20PI;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_step !== EXP_5_73 || out_wrap_err !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL hold_cycle_%0d: got valid=%b step=%0d err=%b ready=%b expected 1/%0d/0/0",
                 i, out_valid, out_step, out_wrap_err, in_ready, EXP_5_73);
      else n_pass++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL hold_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    else n_pass++;

    in_valid = 1'b1;
    in_phase = PH_5_73;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_step !== 4'd0 || out_wrap_err !== 1'b0)
      $display("FAIL abort_outputs: got ready=%b valid=%b step=%0d err=%b expected all 0",
               in_ready, out_valid, out_step, out_wrap_err);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL abort_no_output: got out_valid seen=%b expected 0", seen);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL abort_ready: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_op(PS * 7 + 5, lat, st, err, to);
    n_checks++;
    if (to || st !== 4'd7) $display("FAIL b2b_first: got %0d expected 7", st);
    else n_pass++;
    do_op(-(PS >>> 1), lat, st, err, to);
    n_checks++;
    if (to || st !== EXP_NEG_HALF) $display("FAIL b2b_second: got %0d expected %0d", st, EXP_NEG_HALF);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL b2b_wrap_err: got %b expected 0", err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_two_pi();
    test_quantize();
    test_wrap_err();
    test_hold_and_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
